// File: rtl/flip_flop.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flip_flop                                                  |
// | Description : N-bit register with write enable and synchronous,          |
// |               active-low reset loading RESET_VALUE.                      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+

module flip_flop #(
  parameter int           N           = 32,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  logic [N-1:0] r_data;

  // Reset outranks the write enable; both take effect only on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= RESET_VALUE;
    end else if (we) begin
      r_data <= in;
    end
  end

  assign out = r_data;

endmodule

`default_nettype wire

// File: tb/tb_flip_flop.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_flip_flop                                               |
// | Description : Self-checking bench for flip_flop (chain, reset, widths).  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+

module tb_flip_flop;

  localparam logic [31:0] C_RV32 = 32'hDEADBEEF;

  logic clk;
  int   checks;
  int   errors;

  // Two-stage N=4 chain
  logic       a_rst, a_we;
  logic [3:0] a_in, a_b, a_c;
  // N=1
  logic       n1_rst, n1_we;
  logic [0:0] n1_in, n1_out;
  // N=32, zero and non-zero reset values sharing inputs
  logic        w_rst, w_we;
  logic [31:0] w_in, w_out, w_rout;

  flip_flop #(.N(4)) u_s1 (.clk(clk), .reset(a_rst), .we(a_we), .in(a_in), .out(a_b));
  flip_flop #(.N(4)) u_s2 (.clk(clk), .reset(a_rst), .we(a_we), .in(a_b),  .out(a_c));
  flip_flop #(.N(1)) u_n1 (.clk(clk), .reset(n1_rst), .we(n1_we), .in(n1_in), .out(n1_out));
  flip_flop #(.N(32)) u_w (.clk(clk), .reset(w_rst), .we(w_we), .in(w_in), .out(w_out));
  flip_flop #(.N(32), .RESET_VALUE(C_RV32)) u_wr (
    .clk(clk), .reset(w_rst), .we(w_we), .in(w_in), .out(w_rout));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b0; a_we = 1'b1; a_in = 4'hF;
    n1_rst = 1'b0; n1_we = 1'b1; n1_in = 1'b1;
    w_rst = 1'b0; w_we = 1'b1; w_in = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (a_b !== 4'h0) begin
        errors++; $display("FAIL reset_hold edge %0d: out=%h expected 0", k, a_b);
      end
    end
    checks++;
    if (a_c !== 4'h0) begin
      errors++; $display("FAIL reset_chain: out=%h expected 0", a_c);
    end
    checks++;
    if (n1_out !== 1'b0) begin
      errors++; $display("FAIL reset_n1: out=%h expected 0", n1_out);
    end
    checks++;
    if (w_out !== 32'h0) begin
      errors++; $display("FAIL reset_n32: out=%h expected 0", w_out);
    end
    checks++;
    if (w_rout !== C_RV32) begin
      errors++; $display("FAIL reset_value: out=%h expected %h", w_rout, C_RV32);
    end
  endtask

  task automatic test_chain;
    logic [3:0] prev;
    prev = 4'h0;
    a_rst = 1'b1; a_we = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      #3 a_in = 4'(v);
      step();
      checks++;
      if (a_b !== 4'(v) || a_c !== prev) begin
        errors++;
        $display("FAIL chain A=%0d: B=%h C=%h expected B=%h C=%h", v, a_b, a_c, 4'(v), prev);
      end
      prev = 4'(v);
    end
  endtask

  task automatic test_collision;
    a_rst = 1'b1; a_we = 1'b1; a_in = 4'h5;
    step();
    checks++;
    if (a_b !== 4'h5) begin
      errors++; $display("FAIL collision_load: out=%h expected 5", a_b);
    end
    a_rst = 1'b0; a_in = 4'hA;
    step();
    checks++;
    if (a_b !== 4'h0) begin
      errors++; $display("FAIL collision_reset: out=%h expected 0", a_b);
    end
    a_rst = 1'b1;
    step();
    checks++;
    if (a_b !== 4'hA) begin
      errors++; $display("FAIL collision_release: out=%h expected a", a_b);
    end
  endtask

  task automatic test_we_hold;
    a_rst = 1'b1; a_we = 1'b1; a_in = 4'h9;
    step();
    a_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_in = k[0] ? 4'hC : 4'h3;
      step();
      checks++;
      if (a_b !== 4'h9) begin
        errors++; $display("FAIL we_hold edge %0d: out=%h expected 9", k, a_b);
      end
    end
  endtask

  task automatic test_sync_reset;
    a_rst = 1'b1; a_we = 1'b1; a_in = 4'h7;
    step();
    a_we = 1'b0;
    #2 a_rst = 1'b0;
    #2;
    checks++;
    if (a_b !== 4'h7) begin
      errors++; $display("FAIL async_reset_mid: out=%h expected 7", a_b);
    end
    #2 a_rst = 1'b1;
    step();
    checks++;
    if (a_b !== 4'h7) begin
      errors++; $display("FAIL async_reset_edge: out=%h expected 7", a_b);
    end
  endtask

  task automatic test_width;
    logic [31:0] pats [3];
    pats[0] = 32'hFFFF_FFFF; pats[1] = 32'h0; pats[2] = 32'hA5A5_A5A5;
    n1_rst = 1'b1; n1_we = 1'b1; w_rst = 1'b1; w_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n1_in = pats[k][0:0];
      w_in  = pats[k];
      step();
      checks++;
      if (n1_out !== pats[k][0:0] || w_out !== pats[k] || w_rout !== pats[k]) begin
        errors++;
        $display("FAIL width pat %0d: n1=%h n32=%h n32r=%h expected %h", k, n1_out, w_out, w_rout, pats[k]);
      end
    end
    w_rst = 1'b0;
    step();
    checks++;
    if (w_rout !== C_RV32 || w_out !== 32'h0) begin
      errors++; $display("FAIL width_reset: n32r=%h n32=%h expected %h 0", w_rout, w_out, C_RV32);
    end
  endtask

  // Reference: each edge, reset wins, else enable captures, else hold.
  task automatic test_random;
    logic [3:0]  m1, m2, m1_old;
    logic [0:0]  mn1;
    logic [31:0] mw, mwr;
    int          bad;
    m1 = a_b; m2 = a_c; mn1 = n1_out; mw = w_out; mwr = w_rout;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      a_rst  = ($urandom_range(0, 9) != 0);
      a_we   = 1'($urandom);
      a_in   = 4'($urandom);
      n1_rst = ($urandom_range(0, 9) != 0);
      n1_we  = 1'($urandom);
      n1_in  = 1'($urandom);
      w_rst  = ($urandom_range(0, 9) != 0);
      w_we   = 1'($urandom);
      w_in   = $urandom;
      m1_old = m1;
      if (!a_rst) begin m1 = 4'h0; m2 = 4'h0; end
      else if (a_we) begin m2 = m1_old; m1 = a_in; end
      if (!n1_rst) mn1 = 1'b0; else if (n1_we) mn1 = n1_in;
      if (!w_rst) begin mw = 32'h0; mwr = C_RV32; end
      else if (w_we) begin mw = w_in; mwr = w_in; end
      step();
      checks++;
      if (a_b !== m1 || a_c !== m2 || n1_out !== mn1 || w_out !== mw || w_rout !== mwr) begin
        errors++;
        if (bad < 10)
          $display("FAIL random cyc %0d: B=%h C=%h n1=%h n32=%h n32r=%h expected %h %h %h %h %h",
                   k, a_b, a_c, n1_out, w_out, w_rout, m1, m2, mn1, mw, mwr);
        bad++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a_rst = 1'b0; a_we = 1'b0; a_in = '0;
    n1_rst = 1'b0; n1_we = 1'b0; n1_in = '0;
    w_rst = 1'b0; w_we = 1'b0; w_in = '0;
    #1;
    test_reset();
    test_chain();
    test_collision();
    test_we_hold();
    test_sync_reset();
    test_width();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
